// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - two-requester round-robin scheduler for the dual-port ram block
// Optional build macro RAM_ARB_FIXED_PRIO_EN: requester 0 always wins ties, no rr pointer.
module ram_arb #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic                     req0_write,
  input  logic [ADDR_BITWIDTH-1:0] req0_addr,
  input  logic [DATA_BITWIDTH-1:0] req0_wdata,
  output logic                     req0_ready,
  output logic                     rsp0_valid,
  output logic [DATA_BITWIDTH-1:0] rsp0_rdata,
  input  logic                     req1_valid,
  input  logic                     req1_write,
  input  logic [ADDR_BITWIDTH-1:0] req1_addr,
  input  logic [DATA_BITWIDTH-1:0] req1_wdata,
  output logic                     req1_ready,
  output logic                     rsp1_valid,
  output logic [DATA_BITWIDTH-1:0] rsp1_rdata,
  output logic [ADDR_BITWIDTH-1:0] ram_addr_wr,
  output logic [DATA_BITWIDTH-1:0] ram_data_wr,
  output logic                     ram_wr,
  output logic [ADDR_BITWIDTH-1:0] ram_addr_rd,
  input  logic [DATA_BITWIDTH-1:0] ram_data_rd
);

  typedef enum logic [1:0] {IDLE, WR_SETUP, WR_PULSE, RD} state_t;

  state_t                     state;
  logic                       rd_sel;
  logic                       gnt0;
  logic                       gnt1;
  logic                       acc_write;
  logic [ADDR_BITWIDTH-1:0]   acc_addr;
  logic [DATA_BITWIDTH-1:0]   acc_wdata;

`ifndef RAM_ARB_FIXED_PRIO_EN
  // rr = requester that wins the next tie
  logic rr;
`endif

  // Grant decision: only in IDLE, and never while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      gnt0 = req0_valid & ~(req1_valid & rr);
      gnt1 = req1_valid & ~(req0_valid & ~rr);
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Fields of the granted request; sampled only on the accept cycle
  always_comb begin
    acc_write = gnt1 ? req1_write : req0_write;
    acc_addr  = gnt1 ? req1_addr  : req0_addr;
    acc_wdata = gnt1 ? req1_wdata : req0_wdata;
  end

  // Main sequencer: accept, write setup/pulse, read capture; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_sel      <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr          <= 1'b0;
`endif
      ram_wr      <= 1'b0;
      ram_addr_wr <= '0;
      ram_data_wr <= '0;
      ram_addr_rd <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_rdata  <= '0;
      rsp1_rdata  <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr <= ~gnt1;
`endif
            if (acc_write) begin
              ram_addr_wr <= acc_addr;
              ram_data_wr <= acc_wdata;
              state       <= WR_SETUP;
            end else begin
              ram_addr_rd <= acc_addr;
              rd_sel      <= gnt1;
              state       <= RD;
            end
          end
        end
        WR_SETUP: begin
          // address/data have been stable for a full cycle; raise the strobe
          ram_wr <= 1'b1;
          state  <= WR_PULSE;
        end
        WR_PULSE: begin
          ram_wr <= 1'b0;
          state  <= IDLE;
        end
        RD: begin
          if (rd_sel) begin
            rsp1_rdata <= ram_data_rd;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_rdata <= ram_data_rd;
            rsp0_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb/tb_ram_arb.sv - randomized bench for ram_arb against a cycle-level transaction model
module tb_ram_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [7:0] ram_addr_wr, ram_data_wr, ram_addr_rd, ram_data_rd;
  logic       ram_wr;

  ram_arb #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata),
    .ram_addr_wr(ram_addr_wr), .ram_data_wr(ram_data_wr), .ram_wr(ram_wr),
    .ram_addr_rd(ram_addr_rd), .ram_data_rd(ram_data_rd)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: commits on rising edge of wr, asynchronous read
  logic [7:0] ram_mem [256];
  assign ram_data_rd = ram_mem[ram_addr_rd];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    forever begin
      @(posedge ram_wr);
      ram_mem[ram_addr_wr] = ram_data_wr;
    end
  end

  // Reference model state
  int         errors = 0;
  int         checks = 0;
  int         cyc;
  int         free_at;
  int         prefer;
  int         wr_cyc;
  logic [7:0] wr_addr_e, wr_data_e;
  int         rsp_cyc;
  int         rsp_who;
  logic [7:0] rsp_data_e, rd_addr_e;
  logic [7:0] exp_rdata [2];
  logic [7:0] mem_exp [256];
  int         last_g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at      = cyc;
    prefer       = 0;
    wr_cyc       = -10;
    rsp_cyc      = -10;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
  endtask

  // One clock: check DUT against the model at negedge, apply accept, advance
  task automatic tick();
    int  g;
    bit  b0, b1;
    @(negedge clk);
    g  = -1;
    b0 = (req0_valid === 1'b1);
    b1 = (req1_valid === 1'b1);
    if (cyc >= free_at) begin
      if (b0 && b1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = prefer;
`endif
      end else if (b0) g = 0;
      else if (b1) g = 1;
    end
    check("ready0", {31'd0, req0_ready}, {31'd0, g == 0});
    check("ready1", {31'd0, req1_ready}, {31'd0, g == 1});
    check("ram_wr", {31'd0, ram_wr}, {31'd0, cyc == wr_cyc});
    if (cyc == wr_cyc) mem_exp[wr_addr_e] = wr_data_e;
    if (cyc >= wr_cyc - 1 && cyc <= wr_cyc + 1) begin
      check("ram_addr_wr", {24'd0, ram_addr_wr}, {24'd0, wr_addr_e});
      check("ram_data_wr", {24'd0, ram_data_wr}, {24'd0, wr_data_e});
    end
    if (cyc == rsp_cyc - 1) check("ram_addr_rd", {24'd0, ram_addr_rd}, {24'd0, rd_addr_e});
    check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, cyc == rsp_cyc && rsp_who == 0});
    check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, cyc == rsp_cyc && rsp_who == 1});
    if (cyc == rsp_cyc) exp_rdata[rsp_who] = rsp_data_e;
    check("rsp0_rdata", {24'd0, rsp0_rdata}, {24'd0, exp_rdata[0]});
    check("rsp1_rdata", {24'd0, rsp1_rdata}, {24'd0, exp_rdata[1]});
    last_g = g;
    if (g >= 0) begin
      prefer = 1 - g;
      if ((g == 0) ? req0_write : req1_write) begin
        wr_cyc    = cyc + 2;
        wr_addr_e = (g == 0) ? req0_addr : req1_addr;
        wr_data_e = (g == 0) ? req0_wdata : req1_wdata;
        free_at   = cyc + 3;
      end else begin
        rd_addr_e  = (g == 0) ? req0_addr : req1_addr;
        rsp_cyc    = cyc + 2;
        rsp_who    = g;
        rsp_data_e = mem_exp[rd_addr_e];
        free_at    = cyc + 2;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic req(input int who, input bit wr, input logic [7:0] addr,
                     input logic [7:0] data, output int acc_at);
    acc_at = -1;
    if (who == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = data;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = data;
    end
    for (int i = 0; i < 10 && acc_at < 0; i++) begin
      tick();
      if (last_g == who) acc_at = cyc - 1;
    end
    if (acc_at < 0) check("req_timeout", 32'd0, 32'd1);
    if (who == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic reset_mid();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_addr_wr", {24'd0, ram_addr_wr}, 32'd0);
    check("rst_data_wr", {24'd0, ram_data_wr}, 32'd0);
    check("rst_addr_rd", {24'd0, ram_addr_rd}, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_rdata", {16'd0, rsp1_rdata, rsp0_rdata}, 32'd0);
    if (cyc == wr_cyc) mem_exp[wr_addr_e] = wr_data_e;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  int acc0, acc1;
  int seq [4];
  int n_acc;

  initial begin
    for (int i = 0; i < 256; i++) mem_exp[i] = 8'h00;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    cyc = 0;
    model_reset();
    #12;
    check("reset_outputs",
          {7'd0, ram_wr, req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_addr_wr, ram_data_wr, ram_addr_rd},
          32'd0);
    check("reset_rdata", {16'd0, rsp0_rdata, rsp1_rdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    model_reset();

    // Write 0x12=0xA5 from req0, read back from req1
    req(0, 1'b1, 8'h12, 8'hA5, acc0);
    idle(3);
    req(1, 1'b0, 8'h12, 8'h00, acc1);
    idle(3);
    check("tp_read_a5", {24'd0, rsp1_rdata}, 32'hA5);
    check("tp_rsp0_untouched", {24'd0, rsp0_rdata}, 32'h00);

    // Both requesters hold four reads; record grant order from a fresh reset
    @(posedge clk); #1; cyc++;
    reset_mid();
    idle(1);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h12;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h12;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 4; i++) begin
      tick();
      if (last_g >= 0) begin
        seq[n_acc] = last_g;
        n_acc++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("four_grants_count", n_acc, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      check("grant_order", seq[k], 0);
`else
      check("grant_order", seq[k], k % 2);
`endif
    end
    idle(3);

    // Back-to-back write then read of the same address from the other requester
    req(0, 1'b1, 8'h03, 8'h77, acc0);
    req(1, 1'b0, 8'h03, 8'h00, acc1);
    check("b2b_accept_cycle", acc1, acc0 + 3);
    idle(2);
    check("b2b_read_77", {24'd0, rsp1_rdata}, 32'h77);

    // Reset during WR_SETUP: write abandoned
    req(0, 1'b1, 8'h40, 8'hFF, acc0);
    reset_mid();
    idle(1);
    req(1, 1'b0, 8'h40, 8'h00, acc1);
    idle(2);
    check("abandoned_write", {24'd0, rsp1_rdata}, 32'h00);

    // Reset during WR_PULSE: write committed, strobe drops at once
    req(0, 1'b1, 8'h50, 8'h3C, acc0);
    tick();
    check("pulse_high", {31'd0, ram_wr}, 32'd1);
    reset_mid();
    idle(1);
    req(0, 1'b0, 8'h50, 8'h00, acc1);
    idle(2);
    check("committed_write", {24'd0, rsp0_rdata}, 32'h3C);

    // Randomized traffic over a small address window
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_write = $urandom_range(0, 1) == 1;
      req0_addr  = 8'($urandom_range(0, 7));
      req0_wdata = 8'($urandom);
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_write = $urandom_range(0, 1) == 1;
      req1_addr  = 8'($urandom_range(0, 7));
      req1_wdata = 8'($urandom);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
Name: ram_arb

Overview:
- Two-requester scheduler in front of the team's dual-port `ram` block: async read port (`addr_rd` → `data_rd`); write port that commits on the rising edge of `wr`.
- Accepts read/write requests on valid/ready handshakes and grants one at a time, round-robin.
- Sequences the write strobe so address and data are stable a full cycle before `wr` rises.
- Returns registered read data with a one-cycle response pulse.

Parameters:
DATA_BITWIDTH, 8, RAM word width
ADDR_BITWIDTH, 8, RAM address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a request
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_BITWIDTH  request address
req0_wdata  in  DATA_BITWIDTH  write data
req0_ready  out  1  request accepted this cycle when valid&ready
rsp0_valid  out  1  one-cycle read-data pulse
rsp0_rdata  out  DATA_BITWIDTH  read data, held until next read response
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
ram_addr_wr  out  ADDR_BITWIDTH  to RAM addr_wr
ram_data_wr  out  DATA_BITWIDTH  to RAM data_wr
ram_wr  out  1  to RAM wr; registered, glitch-free
ram_addr_rd  out  ADDR_BITWIDTH  to RAM addr_rd
ram_data_rd  in  DATA_BITWIDTH  from RAM data_rd

Behaviour:
- Reset (rst_n low, async): state IDLE, rr pointer = 0.
- Reset also forces all outputs to 0: ram_wr, ram_addr_wr, ram_data_wr, ram_addr_rd, req*_ready, rsp*_valid, rsp*_rdata.
- States:
  - IDLE: accept requests.
  - WR_SETUP: ram_wr=0, ram_addr_wr/ram_data_wr hold the latched values.
  - WR_PULSE: ram_wr=1 for exactly one cycle.
  - RD: ram_addr_rd holds the latched address.
- Ready: reqN_ready is combinational. It is high only in IDLE and only for the granted requester; at most one ready is high per cycle.
- Arbitration in IDLE:
  - One valid: that requester is granted.
  - Both valid: the requester equal to the rr pointer is granted.
  - On every accept, the rr pointer is set to the other requester.
- Write accepted at cycle T:
  - Addr and data are latched at the end of T.
  - T+1 = WR_SETUP, T+2 = WR_PULSE (RAM commits at the rising edge of ram_wr).
  - T+3 = IDLE; the next accept is possible at T+3.
  - ram_addr_wr and ram_data_wr do not change from T+1 through T+3.
- Read accepted at cycle T:
  - ram_addr_rd is loaded at the end of T.
  - T+1 = RD; ram_data_rd is captured into rspN_rdata of the granted requester at the end of T+1.
  - rspN_valid is high during T+2 only; state returns to IDLE at T+2, so the next accept is possible at T+2.
  - The other requester's rsp_rdata is unchanged.
- Ordering and hazards: a read issued after an accepted write to the same address returns the new data, because the write fully commits before IDLE.
- Request fields are sampled only on the accept cycle; changes at other times are ignored.
- A requester may drop valid without being accepted; no state is affected.
- ram_addr_rd retains its last value outside RD.
- Reset mid-operation:
  - A write in WR_SETUP is abandoned, with no RAM update.
  - In WR_PULSE, the rising edge has already occurred, so the write is committed; ram_wr falls to 0.
  - A pending read response is dropped.
- Width rules: all addresses and data pass through unmodified. No wrap or arithmetic on addresses.

Optional Feature:
- RAM_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid; the rr pointer is not implemented. Requester 1 may starve.
- Not defined: round-robin as above.

Test Plan:
- Reset, then req0 writes addr 0x12 data 0xA5 → req0_ready at T; ram_wr=0 at T+1 with addr 0x12 / data 0xA5; ram_wr=1 at T+2; ram_wr=0 at T+3.
- After the above, req1 reads 0x12 → rsp1_valid for one cycle at T+2 with rsp1_rdata=0xA5; rsp0_valid stays 0.
- Both requesters hold valid for 4 reads → grants alternate 0,1,0,1 starting with 0 after reset. With RAM_ARB_FIXED_PRIO_EN, all 4 grants go to 0.
- Back-to-back: write 0x03=0x77 then read 0x03 from the other requester → read accepted at T+3, returns 0x77.
- Assert rst_n low during WR_SETUP of a write of 0xFF to 0x40 → no ram_wr rising edge; a subsequent read of 0x40 returns the prior value (0 after initialisation).
- Reset asserted during WR_PULSE → ram_wr drops immediately; the data is committed; all outputs are 0 and state is IDLE.
